// File: rtl/channel_accum.sv
// Despread-and-dump correlator channel: signs each complex product by the PRN
// chip, integrates over one code period and hands the sum to a consumer.
// Optional macro CHANNEL_ACCUM_SAT_EN: clamp on accumulator overflow instead of wrapping.
//
// state | meaning
// IDLE  | channel disabled; accumulators held at 0, samples and epochs ignored
// RUN   | integrating valid samples; epoch sample dumps and restarts the sum
module channel_accum #(
  parameter int IN_W  = 6,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  cmplx_product_re,
  input  logic [IN_W-1:0]  cmplx_product_im,
  input  logic             code_bit,
  input  logic             epoch,
  output logic [ACC_W-1:0] dump_re,
  output logic [ACC_W-1:0] dump_im,
  output logic             dump_valid,
  input  logic             dump_ack,
  output logic             overrun,
  output logic             ovf
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             run;
  logic [ACC_W-1:0] acc_re, acc_im;
  logic [ACC_W-1:0] ext_re, ext_im;
  logic [ACC_W-1:0] term_re, term_im;
  logic [ACC_W:0]   add_re, add_im;
  logic             dump_now;

  // Returns {overflow, result}; the sum is formed one bit wider so the
  // overflow test is a simple compare of the top two bits.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] a,
                                             input logic [ACC_W-1:0] b);
    logic [ACC_W:0]   s;
    logic             o;
    logic [ACC_W-1:0] r;
    s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
    o = s[ACC_W] ^ s[ACC_W-1];
    r = s[ACC_W-1:0];
`ifdef CHANNEL_ACCUM_SAT_EN
    if (o) begin
      r = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
    return {o, r};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run     = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        run = enable;
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Negation happens after sign extension, so the most negative input is safe.
  assign ext_re  = {{(ACC_W-IN_W){cmplx_product_re[IN_W-1]}}, cmplx_product_re};
  assign ext_im  = {{(ACC_W-IN_W){cmplx_product_im[IN_W-1]}}, cmplx_product_im};
  assign term_re = code_bit ? (~ext_re + 1'b1) : ext_re;
  assign term_im = code_bit ? (~ext_im + 1'b1) : ext_im;

  assign add_re   = acc_add(acc_re, term_re);
  assign add_im   = acc_add(acc_im, term_im);
  assign dump_now = run & in_valid & epoch;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_re     <= '0;
      acc_im     <= '0;
      dump_re    <= '0;
      dump_im    <= '0;
      dump_valid <= 1'b0;
      overrun    <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (!run) begin
        acc_re <= '0;
        acc_im <= '0;
      end else if (in_valid) begin
        if (add_re[ACC_W] | add_im[ACC_W]) ovf <= 1'b1;
        if (epoch) begin
          acc_re  <= '0;
          acc_im  <= '0;
          dump_re <= add_re[ACC_W-1:0];
          dump_im <= add_im[ACC_W-1:0];
        end else begin
          acc_re <= add_re[ACC_W-1:0];
          acc_im <= add_im[ACC_W-1:0];
        end
      end

      // A new dump always wins over an ack; it is only lost if unread.
      if (dump_now) begin
        dump_valid <= 1'b1;
        if (dump_valid && !dump_ack) overrun <= 1'b1;
      end else if (dump_valid && dump_ack) begin
        dump_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_channel_accum.sv
// Scoreboard bench for channel_accum: expected dumps are queued when the epoch
// sample is driven and compared one clock later when the result appears.
module tb_channel_accum;

  localparam int IN_W  = 6;
  localparam int ACC_W = 24;

  typedef struct {
    int re;
    int im;
    int dv;
    int ovr;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic enable = 1'b0;
  logic en8 = 1'b0;
  logic in_valid = 1'b0;
  logic code_bit = 1'b0;
  logic epoch = 1'b0;
  logic dump_ack = 1'b0;
  logic [IN_W-1:0] prod_re = '0;
  logic [IN_W-1:0] prod_im = '0;

  logic signed [ACC_W-1:0] dump_re, dump_im;
  logic dump_valid, overrun, ovf;
  logic signed [7:0] d8_re, d8_im;
  logic d8_valid, d8_overrun, d8_ovf;

  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  channel_accum #(.IN_W(IN_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid),
    .cmplx_product_re(prod_re), .cmplx_product_im(prod_im),
    .code_bit(code_bit), .epoch(epoch),
    .dump_re(dump_re), .dump_im(dump_im), .dump_valid(dump_valid),
    .dump_ack(dump_ack), .overrun(overrun), .ovf(ovf)
  );

  channel_accum #(.IN_W(IN_W), .ACC_W(8)) dut8 (
    .clk(clk), .reset(reset), .enable(en8), .in_valid(in_valid),
    .cmplx_product_re(prod_re), .cmplx_product_im(prod_im),
    .code_bit(code_bit), .epoch(epoch),
    .dump_re(d8_re), .dump_im(d8_im), .dump_valid(d8_valid),
    .dump_ack(dump_ack), .overrun(d8_overrun), .ovf(d8_ovf)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int re, input int im, input int dv, input int ovr);
    exp_t e;
    e.re = re; e.im = im; e.dv = dv; e.ovr = ovr;
    sb.push_back(e);
  endtask

  // One clock of stimulus; an accepted epoch pops and checks the scoreboard.
  task automatic step(input bit v, input int re, input int im, input bit cb,
                      input bit ep, input bit ack);
    exp_t e;
    in_valid = v;
    prod_re  = IN_W'(re);
    prod_im  = IN_W'(im);
    code_bit = cb;
    epoch    = ep;
    dump_ack = ack;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    epoch    = 1'b0;
    dump_ack = 1'b0;
    if (v && ep && sb.size() > 0) begin
      e = sb.pop_front();
      check("dump_re", dump_re, e.re);
      check("dump_im", dump_im, e.im);
      check("dump_valid", dump_valid, e.dv);
      check("overrun", overrun, e.ovr);
    end
  endtask

  // mode 0: code_bit 0, mode 1: code_bit 1, mode 2: alternate starting at 0
  task automatic burst(input int n, input int re, input int im, input int mode,
                       input bit ack_last);
    bit cb;
    for (int i = 0; i < n; i++) begin
      cb = (mode == 2) ? i[0] : (mode == 1);
      step(1'b1, re, im, cb, i == n - 1, ack_last && (i == n - 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("rst_dump_re", dump_re, 0);
    check("rst_dump_valid", dump_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ovf", ovf, 0);

    enable = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    push_exp(30, -20, 1, 0);
    burst(10, 3, -2, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    check("ack_clears_dv", dump_valid, 0);

    push_exp(0, 0, 1, 0);
    burst(10, 3, -2, 2, 0);

    // epoch together with ack: new result, no overrun
    push_exp(6, -3, 1, 0);
    burst(3, 2, -1, 0, 1);

    // unread result overwritten: most negative input negated
    push_exp(128, -20, 1, 1);
    burst(4, -32, 5, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    check("ack_after_overrun_dv", dump_valid, 0);
    check("overrun_sticky_ack", overrun, 1);
    step(0, 0, 0, 0, 0, 1);
    check("ack_while_idle_dv", dump_valid, 0);

    // epoch without in_valid is ignored and does not split the sum
    step(1, 1, 1, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0);
    step(0, 9, 9, 0, 1, 0);
    check("invalid_epoch_dv", dump_valid, 0);
    push_exp(3, 3, 1, 1);
    step(1, 1, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);

    // enable drop discards partial sums
    repeat (3) step(1, 7, 7, 0, 0, 0);
    enable = 1'b0;
    step(1, 7, 7, 0, 1, 0);
    check("disabled_no_dump", dump_valid, 0);
    enable = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    push_exp(2, 2, 1, 1);
    burst(2, 1, 1, 0, 0);

    // reset mid-epoch with a pending dump, colliding with epoch and ack
    repeat (3) step(1, 5, 5, 0, 0, 0);
    reset    = 1'b1;
    in_valid = 1'b1;
    epoch    = 1'b1;
    dump_ack = 1'b1;
    prod_re  = IN_W'(5);
    prod_im  = IN_W'(5);
    @(posedge clk);
    #1;
    reset = 1'b0; in_valid = 1'b0; epoch = 1'b0; dump_ack = 1'b0;
    check("midrst_dump_re", dump_re, 0);
    check("midrst_dump_im", dump_im, 0);
    check("midrst_dump_valid", dump_valid, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_ovf", ovf, 0);
    step(0, 0, 0, 0, 0, 0);
    push_exp(8, -8, 1, 0);
    burst(2, 4, -4, 0, 0);
    check("ovf_clear_main", ovf, 0);

    // narrow accumulator overflow
    enable = 1'b0;
    en8    = 1'b1;
    step(0, 0, 0, 0, 0, 0);
    burst(5, 31, 0, 0, 0);
`ifdef CHANNEL_ACCUM_SAT_EN
    check("acc8_dump_re", d8_re, 127);
`else
    check("acc8_dump_re", d8_re, -101);
`endif
    check("acc8_ovf", d8_ovf, 1);
    check("acc8_dump_valid", d8_valid, 1);
    check("acc8_dump_im", d8_im, 0);

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/channel_accum.md
CHANNEL_ACCUM -- requirements
Module: channel_accum

Interface
REQ-001 SHALL have parameter IN_W, default 6: signed width of the complex product inputs.
REQ-002 SHALL have parameter ACC_W, default 24: signed width of the accumulators and dump outputs; ACC_W > IN_W.
REQ-003 SHALL have port clk, input, 1: single clock; one clock domain; all registers update on the rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port enable, input, 1: high runs the channel; low holds the accumulators at 0.
REQ-006 SHALL have port in_valid, input, 1: marks a valid product sample on cmplx_product_re and cmplx_product_im.
REQ-007 SHALL have port cmplx_product_re, input, IN_W: signed real product from the complex mixing stage.
REQ-008 SHALL have port cmplx_product_im, input, IN_W: signed imaginary product from the complex mixing stage.
REQ-009 SHALL have port code_bit, input, 1: PRN chip for the current sample; 0 means +1, 1 means -1.
REQ-010 SHALL have port epoch, input, 1: last sample of the code period; only qualified by in_valid.
REQ-011 SHALL have port dump_re, output, ACC_W: registered real correlation result.
REQ-012 SHALL have port dump_im, output, ACC_W: registered imaginary correlation result.
REQ-013 SHALL have port dump_valid, output, 1: result pending; held high until acknowledged.
REQ-014 SHALL have port dump_ack, input, 1: consumer read strobe.
REQ-015 SHALL have port overrun, output, 1: sticky flag, set when a result is lost.
REQ-016 SHALL have port ovf, output, 1: sticky flag, set on accumulator overflow.

Function
REQ-017 SHALL implement states IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE when enable=0.
REQ-018 In IDLE, SHALL hold acc_re and acc_im at 0 and ignore in_valid and epoch; dump registers and flags keep their values.
REQ-019 In RUN, on each in_valid cycle SHALL add term = code_bit ? -product : +product, sign-extended to ACC_W, to each accumulator.
REQ-020 SHALL negate the most negative IN_W value without error, because the term is computed at ACC_W width.
REQ-021 On in_valid & epoch in RUN, SHALL load dump_re/dump_im with acc + term (the epoch sample included) and clear both accumulators to 0 in the same cycle.
REQ-022 SHALL raise dump_valid on the cycle after the qualifying epoch sample (latency 1 clk).
REQ-023 SHALL clear dump_valid on the cycle after dump_ack=1 while dump_valid=1; dump_ack while dump_valid=0 SHALL have no effect.
REQ-024 If a new dump coincides with dump_valid=1 and no dump_ack, SHALL overwrite the dump registers, keep dump_valid=1 and set overrun.
REQ-025 If a new dump coincides with dump_ack, SHALL load the new result, keep dump_valid=1 and leave overrun unchanged.
REQ-026 An epoch with in_valid=0 SHALL be ignored.
REQ-027 Dropping enable mid-epoch SHALL discard the partial sums without producing a dump.
REQ-028 overrun and ovf SHALL clear only on reset.

Reset
REQ-029 On reset=1 at a clock edge, SHALL zero acc_re, acc_im, dump_re, dump_im, dump_valid, overrun and ovf, and enter IDLE.
REQ-030 reset SHALL take priority over every other input in the same cycle, including an epoch or dump_ack.

Configuration
REQ-031 SHALL provide the macro CHANNEL_ACCUM_SAT_EN.
REQ-032 With CHANNEL_ACCUM_SAT_EN defined, an accumulate that overflows SHALL clamp to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) and set ovf.
REQ-033 Without CHANNEL_ACCUM_SAT_EN, the accumulators SHALL wrap in two's complement and still set ovf on signed overflow.

Verification
REQ-034 enable=1, 10 samples re=3, im=-2, code_bit=0, epoch on the 10th -> next cycle dump_re=30, dump_im=-20, dump_valid=1.
REQ-035 Same stimulus with code_bit alternating 0/1 -> dump_re=0, dump_im=0; with re=-32 and code_bit=1 for 4 samples -> dump_re=128.
REQ-036 Two epochs with no dump_ack between them -> the second result is visible, overrun=1, dump_valid stays 1; dump_ack -> dump_valid=0 next cycle.
REQ-037 Epoch and dump_ack in the same cycle -> new result loaded, dump_valid=1, overrun=0.
REQ-038 ACC_W=8, 5 samples of re=31, code_bit=0 -> with the macro, dump_re=127 and ovf=1; without it, dump_re=-101 and ovf=1.
REQ-039 reset asserted mid-epoch with dump_valid=1 -> all outputs 0 the next cycle; the following epoch sums only post-reset samples.
